// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding and the iteration counter width.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Wide enough to hold w-1, never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
// Two half subtractor stages with their borrows OR-ed together.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic hd;
   logic hb;
   logic hb2;

   // x - y first, then the incoming borrow is taken from that difference
   assign hd   = x ^ y;
   assign hb   = ~x & y;
   assign d    = hd ^ bin;
   assign hb2  = ~hd & bin;
   assign bout = hb | hb2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, one bit per clock.
// Single full subtractor cell with its borrow held in a flop.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow_out
);

   localparam int CW = cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t        state;
   logic [W-1:0]  sa;
   logic [W-1:0]  sb;
   logic [W-1:0]  work;
   logic [W-1:0]  work_nx;
   logic [CW-1:0] cnt;
   logic          brw;
   logic          d;
   logic          bo;

   full_subtractor_cell u_cell (
      .x    (sa[0]),
      .y    (sb[0]),
      .bin  (brw),
      .d    (d),
      .bout (bo)
   );

   // New difference bit enters at the MSB; also covers W == 1.
   always_comb begin
      work_nx        = work >> 1;
      work_nx[W-1]   = d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sa         <= '0;
         sb         <= '0;
         work       <= '0;
         cnt        <= '0;
         brw        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  cnt   <= '0;
                  brw   <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sa   <= sa >> 1;
               sb   <= sb >> 1;
               work <= work_nx;
               brw  <= bo;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff       <= work_nx;
                  borrow_out <= bo;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor computing a - b, LSB first, one bit per clock, over a single subtractor cell with a registered borrow. It is the sequential stage downstream of the team's combinational half/full subtractor cells: it feeds them one bit pair per cycle and chains their borrow through a flip-flop. Used where area matters more than latency. Start/busy/done handshake to the controlling logic.

Parameters:
W, 8, operand and result width in bits; legal range W >= 1.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  W  minuend; captured on the accepting edge.
b  input  W  subtrahend; captured on the accepting edge.
busy  output  1  high in SHIFT and DONE states.
done  output  1  one-cycle pulse; result valid.
diff  output  W  a - b modulo 2^W; held until the next completion.
borrow_out  output  1  final borrow: 1 iff a < b (unsigned); held with diff.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers, counter and borrow flop all 0.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. Edge with start=1: load sa<=a and sb<=b into the shift registers, set cnt<=0 and brw<=0, go to SHIFT. start=0: stay.
- SHIFT: each edge, the cell computes d = sa[0]^sb[0]^brw and bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw). Update brw<=bo. sa and sb shift right by 1. The work register shifts right with d entering at the MSB. cnt<=cnt+1. The edge at which cnt==W-1 processes the last bit and goes to DONE.
- SHIFT to DONE transition: on that same edge, diff is loaded with the completed work register (including the final d) and borrow_out with the final bo.
- DONE: done=1 for exactly one cycle, busy=1. The next edge always returns to IDLE.
- Latency: start sampled on edge E0, done high during the cycle after edge E0+W. Next start is accepted at edge E0+W+2 at the earliest. Throughput is one operation per W+2 cycles.
- start while busy (SHIFT or DONE) is ignored. It is neither queued nor does it affect the in-flight operation. a and b are don't-care after capture.
- diff and borrow_out change only on the SHIFT to DONE edge or on reset. They are stable otherwise, including during a later operation.
- Counter width is clog2(W) with a minimum of 1 bit. For W=1 there is exactly one SHIFT cycle.
- Wrap-around: the result is modulo 2^W. Borrow is reported only via borrow_out; it does not saturate.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse. The partial result is discarded.
- done and busy are registered (derived from state flops), with no combinational path from start.

Decomposition:
- Shared package: state encoding typedef (IDLE, SHIFT, DONE) and a clog2-based counter-width constant function.
- One sub-module: full_subtractor_cell (inputs x, y, bin; outputs d, bout), built from two half subtractor cells plus an OR. It is instantiated once, combinationally, inside serial_subtractor.

Test Plan:
- W=8, a=0x5A, b=0x3C, start pulse -> done exactly 9 cycles after the start edge, diff=0x1E, borrow_out=0; busy high for 9 cycles.
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. a=0xA5, b=0xA5 -> diff=0x00, borrow_out=0.
- start held high continuously with changing a/b -> operations accepted only in IDLE (every 10 cycles). Each result matches the operands present on its accepting edge.
- Assert rst at SHIFT cycle 4 of a=0xF0, b=0x0F -> outputs 0 immediately, no done, IDLE. A fresh start then computes 0xE1 with borrow_out 0.
- After a result is produced, run a=0x10, b=0x20 -> old diff/borrow_out held until done, then diff=0xF0, borrow_out=1.
- W=1: a=0, b=1 -> done 2 cycles after start, diff=1, borrow_out=1. Also a random exhaustive 8-bit sweep checked against the reference model {borrow,diff} = {1'b0,a} - {1'b0,b}.
